// File: rtl/riscv_bp_gshare.sv
// gshare branch direction predictor with a direct-mapped BTB.
// The 2-bit counter table is swept to weakly-not-taken after every reset,
// then looked up from the fetch PC and trained by the branch unit in EX.
module riscv_bp_gshare #(
  parameter int              XLEN              = 32,
  parameter logic [XLEN-1:0] PC_INIT           = 'h200,
  parameter int              BP_GLOBAL_BITS    = 2,
  parameter int              BP_LOCAL_BITS     = 10,
  parameter int              BP_LOCAL_BITS_LSB = 2,
  parameter int              BTB_ENTRIES       = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      id_stall_i,
  input  logic [XLEN-1:0]           if_parcel_pc_i,
  output logic [1:0]                bp_bp_predict_o,
  output logic                      bp_btb_hit_o,
  output logic [XLEN-1:0]           bp_btb_target_o,
  output logic [BP_GLOBAL_BITS-1:0] bp_history_o,
  output logic                      bp_ready_o,
  input  logic [XLEN-1:0]           ex_pc_i,
  input  logic [BP_GLOBAL_BITS-1:0] bu_bp_history_i,
  input  logic [1:0]                bu_bp_predict_i,
  input  logic                      bu_bp_btaken_i,
  input  logic                      bu_bp_update_i,
  input  logic                      bu_btb_update_i,
  input  logic [XLEN-1:0]           bu_nxt_pc_i
);

  localparam int G      = BP_GLOBAL_BITS;
  localparam int L      = BP_LOCAL_BITS;
  localparam int LSB    = BP_LOCAL_BITS_LSB;
  localparam int IDX_W  = G + L;
  localparam int CNT_N  = 1 << IDX_W;
  localparam int BTB_IW = $clog2(BTB_ENTRIES);
  localparam int TAG_W  = XLEN - LSB - BTB_IW;

  typedef enum logic {INIT, RUN} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] init_cnt, init_cnt_nxt;
  logic [G-1:0]     ghr;
  logic [G:0]       ghr_shift;

  logic [1:0]       cnt_tab [CNT_N];
  logic             btb_valid [BTB_ENTRIES];
  logic [TAG_W-1:0] btb_tag [BTB_ENTRIES];
  logic [XLEN-1:0]  btb_target [BTB_ENTRIES];

  logic              run, do_upd, do_btb;
  logic [IDX_W-1:0]  lk_idx, up_idx;
  logic [1:0]        cnt_new, cnt_rd;
  logic [BTB_IW-1:0] lk_bidx, up_bidx;
  logic [TAG_W-1:0]  lk_tag, up_tag;
  logic              hit_rd;
  logic [XLEN-1:0]   tgt_rd;

  assign run    = (state == RUN);
  assign do_upd = run & bu_bp_update_i;
  assign do_btb = run & bu_btb_update_i;

  assign lk_idx  = {ghr, if_parcel_pc_i[LSB+L-1:LSB]};
  assign up_idx  = {bu_bp_history_i, ex_pc_i[LSB+L-1:LSB]};
  assign lk_bidx = if_parcel_pc_i[LSB+BTB_IW-1:LSB];
  assign up_bidx = ex_pc_i[LSB+BTB_IW-1:LSB];
  assign lk_tag  = if_parcel_pc_i[XLEN-1:LSB+BTB_IW];
  assign up_tag  = ex_pc_i[XLEN-1:LSB+BTB_IW];

  // Concatenate-then-truncate keeps the shift legal for a 1-bit history.
  assign ghr_shift = {ghr, bu_bp_btaken_i};

  // Low PC bits below the index window carry no prediction information.
  generate
    if (LSB > 0) begin : g_lsb
      logic unused_pc_lsb;
      assign unused_pc_lsb = ^{if_parcel_pc_i[LSB-1:0], ex_pc_i[LSB-1:0]};
    end
  endgenerate

  // Saturating counter step and write-first bypass for the lookup ports.
  always_comb begin
    cnt_new = bu_bp_predict_i;
    if (bu_bp_btaken_i) begin
      if (bu_bp_predict_i != 2'b11) cnt_new = bu_bp_predict_i + 2'd1;
    end else begin
      if (bu_bp_predict_i != 2'b00) cnt_new = bu_bp_predict_i - 2'd1;
    end
    cnt_rd = cnt_tab[lk_idx];
    if (do_upd && (up_idx == lk_idx)) cnt_rd = cnt_new;
    hit_rd = btb_valid[lk_bidx] && (btb_tag[lk_bidx] == lk_tag);
    tgt_rd = btb_target[lk_bidx];
    if (do_btb && (up_bidx == lk_bidx)) begin
      hit_rd = (up_tag == lk_tag);
      tgt_rd = bu_nxt_pc_i;
    end
  end

  // FSM next state: sweep every counter once, then stay in RUN.
  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    case (state)
      INIT: begin
        init_cnt_nxt = init_cnt + IDX_W'(1);
        if (init_cnt == {IDX_W{1'b1}}) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
    end
  end

  // Counter table single write port: init sweep or branch-unit training.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state == INIT)  cnt_tab[init_cnt] <= 2'b01;
      else if (do_upd)    cnt_tab[up_idx]   <= cnt_new;
    end
  end

  // Global history shifts in each resolved direction.
  always_ff @(posedge clk_i) begin
    if (rst_i)       ghr <= '0;
    else if (do_upd) ghr <= ghr_shift[G-1:0];
  end

  // BTB write; tags and targets are cleared too so outputs never go X.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
      end
    end else if (do_btb) begin
      btb_valid[up_bidx]  <= 1'b1;
      btb_tag[up_bidx]    <= up_tag;
      btb_target[up_bidx] <= bu_nxt_pc_i;
    end
  end

  // Registered lookup outputs; held during init and while ID stalls.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bp_bp_predict_o <= 2'b00;
      bp_btb_hit_o    <= 1'b0;
      bp_btb_target_o <= PC_INIT;
      bp_history_o    <= '0;
    end else if (run && !id_stall_i) begin
      bp_bp_predict_o <= cnt_rd;
      bp_btb_hit_o    <= hit_rd;
      bp_btb_target_o <= tgt_rd;
      bp_history_o    <= ghr;
    end
  end

  assign bp_ready_o = run;

endmodule
